// File: rtl/exe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exe_pkg                                                      |
// | Description : Shared definitions for the registered execute stage:         |
// |               ALU opcode encodings, CPSR flag bit positions, FSM state     |
// |               type and a helper that packs N/Z/C/V into a CPSR word.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package exe_pkg;

  localparam logic [2:0] C_OC_ADD = 3'd0;
  localparam logic [2:0] C_OC_SUB = 3'd1;
  localparam logic [2:0] C_OC_AND = 3'd2;
  localparam logic [2:0] C_OC_OR  = 3'd3;
  localparam logic [2:0] C_OC_XOR = 3'd4;
  localparam logic [2:0] C_OC_LSL = 3'd5;
  localparam logic [2:0] C_OC_LSR = 3'd6;
  localparam logic [2:0] C_OC_MUL = 3'd7;

  localparam int C_FLAG_N = 31;
  localparam int C_FLAG_Z = 30;
  localparam int C_FLAG_C = 29;
  localparam int C_FLAG_V = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } exe_state_t;

  function automatic logic [31:0] pack_cpsr(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [31:0] flags;
    flags           = '0;
    flags[C_FLAG_N] = n;
    flags[C_FLAG_Z] = z;
    flags[C_FLAG_C] = c;
    flags[C_FLAG_V] = v;
    return flags;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exe_mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exe_mul_iter                                                 |
// | Description : Iterative shift-add multiplier, one partial product per      |
// |               cycle. The start cycle performs the first iteration on the   |
// |               live operands, so WIDTH iterations finish WIDTH-1 cycles     |
// |               after start; done is high during the final iteration and     |
// |               product holds the full 2*WIDTH result from the next cycle.   |
// | Ports       : clk, rst_n (async, active-low), start, a, b -> done, product |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exe_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [2*WIDTH-1:0] w_acc_in;
  logic [2*WIDTH-1:0] w_mcand_in;
  logic [WIDTH-1:0]   w_mplier_in;

  always_comb begin
    // On start the iteration works directly on the incoming operands.
    w_acc_in    = start ? '0 : acc_q;
    w_mcand_in  = start ? {{WIDTH{1'b0}}, a} : mcand_q;
    w_mplier_in = start ? b : mplier_q;

    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    if (start || (cnt_q != '0)) begin
      acc_d    = w_mplier_in[0] ? (w_acc_in + w_mcand_in) : w_acc_in;
      mcand_d  = w_mcand_in << 1;
      mplier_d = w_mplier_in >> 1;
      cnt_d    = start ? CNT_W'(WIDTH - 1) : (cnt_q - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done    = (cnt_q == CNT_W'(1));
  assign product = acc_q;

endmodule
`default_nettype wire

// File: rtl/exe_stage_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exe_stage_pipe                                               |
// | Description : Registered execute stage. Selects operand2 (register or      |
// |               immediate), runs a single-cycle ALU, computes N/Z/C/V into   |
// |               a CPSR-format word and registers result/flags/illegal behind |
// |               valid/ready handshakes.                                      |
// | Config      : EXE_MUL_EN - builds the iterative multiplier (MUL takes      |
// |               WIDTH+1 cycles). Undefined: MUL returns 0 with illegal=1.    |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               in_valid/in_ready, value1, value2, immediate, ir_op, alu_oc, |
// |               set_flags  -> upstream op                                    |
// |               out_valid/out_ready, result, cpsr_flags, illegal -> output   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  input  logic [WIDTH-1:0] immediate,
  input  logic             ir_op,
  input  logic [2:0]       alu_oc,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [31:0]      cpsr_flags,
  output logic             illegal
);

  exe_state_t       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [31:0]      cpsr_q, cpsr_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0]   w_op2;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH:0]     w_sum, w_diff, w_lsl, w_lsr;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_c, w_v;
  logic [31:0]        w_alu_flags;
  logic               w_accept;

  assign w_op2   = ir_op ? value2 : immediate;
  assign w_shamt = w_op2[SHAMT_W-1:0];

  // Single-cycle ALU. Shifts run on a one-bit-extended copy so the last bit
  // shifted out lands in the extra bit; a zero shift leaves that bit at 0.
  always_comb begin
    w_sum     = {1'b0, value1} + {1'b0, w_op2};
    w_diff    = {1'b0, value1} - {1'b0, w_op2};
    w_lsl     = {1'b0, value1} << w_shamt;
    w_lsr     = {value1, 1'b0} >> w_shamt;
    w_alu_res = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    case (alu_oc)
      C_OC_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_c       = w_sum[WIDTH];
        w_v       = (value1[WIDTH-1] == w_op2[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != value1[WIDTH-1]);
      end
      C_OC_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_c       = ~w_diff[WIDTH];  // carry = NOT borrow
        w_v       = (value1[WIDTH-1] != w_op2[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != value1[WIDTH-1]);
      end
      C_OC_AND: w_alu_res = value1 & w_op2;
      C_OC_OR:  w_alu_res = value1 | w_op2;
      C_OC_XOR: w_alu_res = value1 ^ w_op2;
      C_OC_LSL: begin
        w_alu_res = w_lsl[WIDTH-1:0];
        w_c       = w_lsl[WIDTH];
      end
      C_OC_LSR: begin
        w_alu_res = w_lsr[WIDTH:1];
        w_c       = w_lsr[0];
      end
      default: ;  // MUL is produced by the FSM path
    endcase
  end

  assign w_alu_flags = pack_cpsr(w_alu_res[WIDTH-1], (w_alu_res == '0), w_c, w_v);

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef EXE_MUL_EN
  logic               mul_sf_q, mul_sf_d;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;

  exe_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .a       (value1),
    .b       (w_op2),
    .done    (w_mul_done),
    .product (w_product)
  );
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    cpsr_d      = cpsr_q;
    illegal_d   = illegal_q;
`ifdef EXE_MUL_EN
    mul_sf_d    = mul_sf_q;
    w_mul_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (alu_oc == C_OC_MUL) begin
`ifdef EXE_MUL_EN
            w_mul_start = 1'b1;
            mul_sf_d    = set_flags;
            state_d     = ST_MUL;
`else
            out_valid_d = 1'b1;
            result_d    = '0;
            illegal_d   = 1'b1;
`endif
          end else begin
            out_valid_d = 1'b1;
            result_d    = w_alu_res;
            illegal_d   = 1'b0;
            if (set_flags) begin
              cpsr_d = w_alu_flags;
            end
          end
        end
      end
`ifdef EXE_MUL_EN
      ST_MUL: begin
        if (w_mul_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Wait here if the previous result is still held by backpressure.
        if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          result_d    = w_product[WIDTH-1:0];
          illegal_d   = 1'b0;
          if (mul_sf_q) begin
            cpsr_d = pack_cpsr(w_product[WIDTH-1], (w_product[WIDTH-1:0] == '0),
                               1'b0, |w_product[2*WIDTH-1:WIDTH]);
          end
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cpsr_q      <= '0;
      illegal_q   <= 1'b0;
`ifdef EXE_MUL_EN
      mul_sf_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cpsr_q      <= cpsr_d;
      illegal_q   <= illegal_d;
`ifdef EXE_MUL_EN
      mul_sf_q    <= mul_sf_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign cpsr_flags = cpsr_q;
  assign illegal    = illegal_q;

endmodule
`default_nettype wire
